// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic (read and write sides).
package async_fifo_pkg;

  // Occupancy of the read-side 2-entry output buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  // Width of a FIFO pointer: address bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 32'd1;
  endfunction

  // Width-generic through zero-extension: callers cast in and out of 32 bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down, done in log2 steps.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int unsigned s = 1; s < 32; s = s << 1) begin
      bin = bin ^ (bin >> s);
    end
    return bin;
  endfunction

endpackage

// File: rtl/pointer_synchronizer.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
module pointer_synchronizer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] stage1;

  // Two capture stages; both clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage1  <= '0;
      dataOut <= '0;
    end else begin
      stage1  <= dataIn;
      dataOut <= stage1;
    end
  end

endmodule

// File: rtl/async_fifo_read_control.sv
// Read-side controller of the dual-clock FIFO: empty detection, memory fetch,
// 2-entry output buffer presenting a first-word-fall-through stream.
module async_fifo_read_control
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATAWIDTH    = 8,
  parameter int unsigned DATADEPTH    = 8,
  parameter int unsigned ADDRESSWIDTH = $clog2(DATADEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRESSWIDTH:0]   writePointerGray,
  input  logic [DATAWIDTH-1:0]    memData,
  output logic [ADDRESSWIDTH-1:0] readAddress,
  output logic [ADDRESSWIDTH:0]   readPointerGray,
  output logic [DATAWIDTH-1:0]    dataOut,
  output logic                    dataValid,
  input  logic                    dataReady,
  output logic                    fifoEmpty,
  output logic [ADDRESSWIDTH:0]   readLevel
);

  localparam int unsigned PW = ADDRESSWIDTH + 1;

  logic [PW-1:0]        syncWriteGray;
  logic [PW-1:0]        syncWriteBin;
  logic [PW-1:0]        readPtrBin;
  logic [PW-1:0]        readPtrNext;
  logic                 inFlight;
  logic                 issue;
  logic                 pop;
  logic [1:0]           heldCount;
  logic [1:0]           afterPop;
  buf_state_t           bufState;
  buf_state_t           bufNext;
  logic [DATAWIDTH-1:0] headWord;
  logic [DATAWIDTH-1:0] tailWord;

  pointer_synchronizer #(
    .WIDTH(PW)
  ) u_write_sync (
    .clk    (clk),
    .reset  (reset),
    .dataIn (writePointerGray),
    .dataOut(syncWriteGray)
  );

  assign syncWriteBin = PW'(gray2bin(32'(syncWriteGray)));
  assign readPtrNext  = readPtrBin + PW'(1);
  assign fifoEmpty    = (syncWriteGray == readPointerGray);
  assign readLevel    = syncWriteBin - readPtrBin;
  assign readAddress  = readPtrBin[ADDRESSWIDTH-1:0];
  assign dataValid    = (bufState != BUF_EMPTY);
  assign dataOut      = headWord;
  assign pop          = dataValid && dataReady;

  // Issue a fetch while words remain and buffer + in-flight stays within 2.
  always_comb begin
    heldCount = 2'd0;
    case (bufState)
      BUF_ONE: heldCount = 2'd1;
      BUF_TWO: heldCount = 2'd2;
      default: heldCount = 2'd0;
    endcase
    // A pop implies heldCount >= 1, so this never goes negative.
    afterPop = heldCount + {1'b0, inFlight} - {1'b0, pop};
    issue    = !fifoEmpty && (afterPop < 2'd2);
  end

  // Read pointer (binary and Gray updated together) and fetch-in-flight flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      readPtrBin      <= '0;
      readPointerGray <= '0;
      inFlight        <= 1'b0;
    end else begin
      inFlight <= issue;
      if (issue) begin
        readPtrBin      <= readPtrNext;
        readPointerGray <= PW'(bin2gray(32'(readPtrNext)));
      end
    end
  end

  // Output buffer occupancy state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      bufState <= BUF_EMPTY;
    end else begin
      bufState <= bufNext;
    end
  end

  // Occupancy next state from returning word (inFlight) and pop.
  always_comb begin
    bufNext = bufState;
    case (bufState)
      BUF_EMPTY: if (inFlight) bufNext = BUF_ONE;
      BUF_ONE: begin
        if (inFlight && !pop)      bufNext = BUF_TWO;
        else if (!inFlight && pop) bufNext = BUF_EMPTY;
      end
      BUF_TWO: if (pop && !inFlight) bufNext = BUF_ONE;
      default: bufNext = BUF_EMPTY;
    endcase
  end

  // Buffer data: a returning word lands behind any word that survives the pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      headWord <= '0;
      tailWord <= '0;
    end else begin
      case (bufState)
        BUF_EMPTY: if (inFlight) headWord <= memData;
        BUF_ONE: begin
          if (inFlight) begin
            if (pop) headWord <= memData;
            else     tailWord <= memData;
          end
        end
        BUF_TWO: begin
          if (pop) begin
            headWord <= tailWord;
            if (inFlight) tailWord <= memData;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
